fpu_issue_unit: RTL

Sequencing stage directly upstream of the combinational single-precision FPU in the CPU execute path. Accepts one FP operation at a time from the pipeline over a valid/ready handshake and registers its operands and SELECT code. Drives the FPU from those registers and waits a per-operation latency so that long combinational paths (divide, fused multiply-add) settle over several cycles. Captures the FPU result and presents it downstream with its destination register tag; BUSY stalls the front-end while an operation is in flight.

---
 rtl/fpu_issue_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fpu_issue_unit.sv
// Single-op sequencer ahead of the combinational FPU: registers operands, waits 1..16 cycles per SELECT, then holds the result.
// IN_READY only in IDLE or when the held result retires the same cycle; the result holds while OUT_READY is low.
module fpu_issue_unit #(
  parameter int BASE_LATENCY = 1,
  parameter int FMA_LATENCY  = 2,
  parameter int DIV_LATENCY  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_DATA1,
  input  logic [31:0] IN_DATA2,
  input  logic [31:0] IN_DATA3,
  input  logic [4:0]  IN_SELECT,
  input  logic [4:0]  IN_RD,
  output logic [31:0] FPU_DATA1,
  output logic [31:0] FPU_DATA2,
  output logic [31:0] FPU_DATA3,
  output logic [4:0]  FPU_SELECT,
  input  logic [31:0] FPU_RESULT,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_RESULT,
  output logic [4:0]  OUT_RD,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_data1;
  logic [31:0] r_data2;
  logic [31:0] r_data3;
  logic [4:0]  r_select;
  logic [4:0]  r_rd;
  logic [31:0] r_result;
  logic [4:0]  r_out_rd;
  logic        r_out_valid;
  logic        w_accept;
  logic        w_exec_done;
  logic [3:0]  w_lat_m1;

  // Counter is preloaded with latency-1 so that CNT==0 marks the final EXEC cycle.
  always_comb begin
    w_lat_m1 = 4'(BASE_LATENCY - 1);
    if (IN_SELECT == 5'b00100) begin
      w_lat_m1 = 4'(DIV_LATENCY - 1);
    end else if (IN_SELECT >= 5'b01110 && IN_SELECT <= 5'b10001) begin
      w_lat_m1 = 4'(FMA_LATENCY - 1);
    end
  end

  assign IN_READY    = !FLUSH && ((r_state == IDLE) || (r_state == DONE && OUT_READY));
  assign w_accept    = IN_VALID && IN_READY;
  assign w_exec_done = (r_state == EXEC) && (r_cnt == 4'd0);

  always_comb begin
    w_next_state = r_state;
    if (FLUSH) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_accept) w_next_state = EXEC;
        EXEC: if (r_cnt == 4'd0) w_next_state = DONE;
        DONE: begin
          if (w_accept) w_next_state = EXEC;
          else if (OUT_READY) w_next_state = IDLE;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt       <= 4'd0;
      r_data1     <= 32'd0;
      r_data2     <= 32'd0;
      r_data3     <= 32'd0;
      r_select    <= 5'd0;
      r_rd        <= 5'd0;
      r_result    <= 32'd0;
      r_out_rd    <= 5'd0;
      r_out_valid <= 1'b0;
    end else if (FLUSH) begin
      r_cnt       <= 4'd0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data1  <= IN_DATA1;
        r_data2  <= IN_DATA2;
        r_data3  <= IN_DATA3;
        r_select <= IN_SELECT;
        r_rd     <= IN_RD;
        r_cnt    <= w_lat_m1;
      end else if (r_state == EXEC && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_exec_done) begin
        r_result    <= FPU_RESULT;
        r_out_rd    <= r_rd;
        r_out_valid <= 1'b1;
      end else if (r_state == DONE && OUT_READY) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign FPU_DATA1  = r_data1;
  assign FPU_DATA2  = r_data2;
  assign FPU_DATA3  = r_data3;
  assign FPU_SELECT = r_select;
  assign OUT_VALID  = r_out_valid;
  assign OUT_RESULT = r_result;
  assign OUT_RD     = r_out_rd;
  assign BUSY       = (r_state != IDLE);

endmodule
